vec_alu_seq: RTL
================

VEC_ALU_SEQ -- requirements
Module: vec_alu_seq

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ELEM_W, 8, element width in bits.
- NUM_ELEMS, 16, elements per vector.
- LANES, 4, elements processed per cycle; must divide NUM_ELEMS.
- TAG_W, 5, destination-register tag width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-low reset.
- flush, in, 1, abort the current operation.
- in_valid, in, 1, operation offered.
- in_ready, out, 1, unit can accept an operation.
- op, in, 4, operation code.
- srcA, in, NUM_ELEMS*ELEM_W, vector operand A.
- srcB, in, NUM_ELEMS*ELEM_W, vector operand B.
- rd_in, in, TAG_W, destination tag.
- out_valid, out, 1, result available.
- out_ready, in, 1, consumer accepts the result.
- result, out, NUM_ELEMS*ELEM_W, result vector.
- rd_out, out, TAG_W, tag of the result.

Function
REQ-003 The FSM SHALL have three states, IDLE, EXEC and DONE; in_ready is 1 only in IDLE.
REQ-004 An operation SHALL be accepted when in_valid&&in_ready; on acceptance srcA, srcB, op and rd_in are captured, the chunk counter is cleared, and the state goes to EXEC.
REQ-005 Each EXEC cycle SHALL compute elements [cnt*LANES, cnt*LANES+LANES-1] into the result register and increment cnt.
REQ-006 When the last chunk (cnt==NUM_ELEMS/LANES-1) is written, the state SHALL go to DONE; acceptance-to-out_valid latency is exactly NUM_ELEMS/LANES cycles.
REQ-007 In DONE, out_valid=1 and result/rd_out SHALL hold stable until out_ready=1; on that edge the state returns to IDLE.
REQ-008 A new operation SHALL NOT be accepted in the cycle the result is consumed; in_ready rises the following cycle.
REQ-009 Ops SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 PASSA; any other code yields zero elements.
REQ-010 ADD/SUB SHALL wrap modulo 2^ELEM_W; SHL/SHR SHALL be logical, shift amount = srcB element mod ELEM_W.
REQ-011 Elements SHALL be independent: no carry or shift propagates across element boundaries.
REQ-012 flush=1 SHALL force the state to IDLE, clear out_valid and cnt, and take priority over acceptance and completion in the same cycle; result contents are don't-care.
REQ-013 With LANES==NUM_ELEMS, EXEC SHALL last exactly one cycle.

Reset
REQ-014 On a clk edge with reset=0, the unit SHALL set state=IDLE, cnt=0, out_valid=0, result=0 and rd_out=0; in_ready is 1 once reset deasserts.
REQ-015 Reset asserted mid-EXEC or mid-DONE SHALL discard the operation with no out_valid pulse.
REQ-016 reset SHALL have priority over flush.

Configuration
REQ-017 With macro VEC_ALU_SAT_EN defined, op 8 SHALL be unsigned saturating add (clamp to 2^ELEM_W-1) and op 9 SHALL be unsigned saturating sub (clamp to 0).
REQ-018 Without VEC_ALU_SAT_EN, ops 8 and 9 SHALL yield zero elements, and no saturation logic is synthesised.

Structure
REQ-019 A package vec_alu_pkg SHALL hold the op-code enum, the FSM state enum and the default-width constants.
REQ-020 Per-element arithmetic SHALL be one combinational sub-module, vec_lane_alu (ELEM_W, op, a, b -> y), instantiated LANES times.

Verification
REQ-021 Defaults, ADD, every A element 0xFF, B element 0x01 -> all result elements 0x00; out_valid exactly 4 cycles after acceptance.
REQ-022 SUB, A=0x00, B=0x01 -> 0xFF; the same stimulus under VEC_ALU_SAT_EN with op 9 -> 0x00; op 8 with 0xF0+0x20 -> 0xFF.
REQ-023 out_ready held low for 10 cycles in DONE -> result and rd_out stable, in_ready=0; in_ready=1 on the cycle after out_ready rises.
REQ-024 flush in the 2nd EXEC cycle -> out_valid never asserts; in_ready=1 the next cycle; the next op completes correctly.
REQ-025 reset=0 during DONE -> all outputs zero, state IDLE.
REQ-026 LANES=16, SHL, A=0x01, B element i = i -> element i = 1<<(i mod 8); latency 1 cycle.

Source files
------------

// File: rtl/vec_alu_pkg.sv
// Shared types and default widths for the multi-cycle vector ALU.
// Op codes 8/9 are only implemented when VEC_ALU_SAT_EN is defined.
package vec_alu_pkg;

  localparam int DEF_ELEM_W    = 8;
  localparam int DEF_NUM_ELEMS = 16;
  localparam int DEF_LANES     = 4;
  localparam int DEF_TAG_W     = 5;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_XOR    = 4'd4,
    OP_SHL    = 4'd5,
    OP_SHR    = 4'd6,
    OP_PASSA  = 4'd7,
    OP_SATADD = 4'd8,
    OP_SATSUB = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/vec_lane_alu.sv
// Single-element combinational ALU; lanes never share carries or shifts.
// Saturating ops exist only when VEC_ALU_SAT_EN is defined.
module vec_lane_alu
  import vec_alu_pkg::*;
#(
  parameter int ELEM_W = DEF_ELEM_W
) (
  input  logic [3:0]        op,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [ELEM_W-1:0] y
);

  logic [ELEM_W-1:0] shamt;
  assign shamt = ELEM_W'(b % ELEM_W);

`ifdef VEC_ALU_SAT_EN
  function automatic logic [ELEM_W-1:0] sat_add(input logic [ELEM_W-1:0] x,
                                                input logic [ELEM_W-1:0] z);
    logic [ELEM_W:0] sum;
    sum = {1'b0, x} + {1'b0, z};
    return sum[ELEM_W] ? '1 : sum[ELEM_W-1:0];
  endfunction

  function automatic logic [ELEM_W-1:0] sat_sub(input logic [ELEM_W-1:0] x,
                                                input logic [ELEM_W-1:0] z);
    return (x < z) ? '0 : x - z;
  endfunction
`endif

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:    y = a + b;
      OP_SUB:    y = a - b;
      OP_AND:    y = a & b;
      OP_OR:     y = a | b;
      OP_XOR:    y = a ^ b;
      OP_SHL:    y = a << shamt;
      OP_SHR:    y = a >> shamt;
      OP_PASSA:  y = a;
`ifdef VEC_ALU_SAT_EN
      OP_SATADD: y = sat_add(a, b);
      OP_SATSUB: y = sat_sub(a, b);
`endif
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/vec_alu_seq.sv
// Multi-cycle vector ALU: LANES elements per EXEC cycle, result held in DONE.
// Optional saturating ops are enabled with VEC_ALU_SAT_EN.
module vec_alu_seq
  import vec_alu_pkg::*;
#(
  parameter int ELEM_W    = DEF_ELEM_W,
  parameter int NUM_ELEMS = DEF_NUM_ELEMS,
  parameter int LANES     = DEF_LANES,
  parameter int TAG_W     = DEF_TAG_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [3:0]                  op,
  input  logic [NUM_ELEMS*ELEM_W-1:0] srcA,
  input  logic [NUM_ELEMS*ELEM_W-1:0] srcB,
  input  logic [TAG_W-1:0]            rd_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_ELEMS*ELEM_W-1:0] result,
  output logic [TAG_W-1:0]            rd_out
);

  localparam int VEC_W      = NUM_ELEMS * ELEM_W;
  localparam int CHUNK_W    = LANES * ELEM_W;
  localparam int NUM_CHUNKS = NUM_ELEMS / LANES;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [VEC_W-1:0]   a_q;
  logic [VEC_W-1:0]   b_q;
  logic [3:0]         op_q;
  logic [CHUNK_W-1:0] lane_y;
  logic               last_chunk;

  assign last_chunk = (cnt == CNT_W'(NUM_CHUNKS - 1));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [ELEM_W-1:0] lane_a;
    logic [ELEM_W-1:0] lane_b;
    assign lane_a = a_q[(int'(cnt) * LANES + l) * ELEM_W +: ELEM_W];
    assign lane_b = b_q[(int'(cnt) * LANES + l) * ELEM_W +: ELEM_W];
    vec_lane_alu #(.ELEM_W(ELEM_W)) u_lane (
      .op (op_q),
      .a  (lane_a),
      .b  (lane_b),
      .y  (lane_y[l*ELEM_W +: ELEM_W])
    );
  end

  // Control and output registers; flush outranks acceptance and completion
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      result    <= '0;
      rd_out    <= '0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= srcA;
            b_q      <= srcB;
            op_q     <= op;
            rd_out   <= rd_in;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          result[int'(cnt) * CHUNK_W +: CHUNK_W] <= lane_y;
          if (last_chunk) begin
            cnt       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
